// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fetch_sequencer
// Brief   : 8-phase cycle generator, PC, circular return stack and two-word
//           instruction fetcher for a 4004-class core.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 3 * DATA_W,
  parameter int STACK_DEPTH = 3,
  parameter int SP_W        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [DATA_W-1:0]     romData,
  input  logic                  longInstr,
  input  logic                  pcLoad,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_W-1:0]     pcNew,
  output logic [2:0]            cycle,
  output logic                  sync,
  output logic [DATA_W-1:0]     busNibble,
  output logic [ADDR_W-1:0]     pcAddr,
  output logic [DATA_W-1:0]     opr,
  output logic [DATA_W-1:0]     opa,
  output logic [2*DATA_W-1:0]   operand,
  output logic                  secondWord,
  output logic                  instrValid,
  output logic [SP_W-1:0]       sp,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam logic [CNT_W-1:0] c_FULL   = CNT_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]  c_SP_TOP = SP_W'(STACK_DEPTH - 1);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  phase_t              r_phase;
  phase_t              w_phaseNext;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pcNext;
  logic [ADDR_W-1:0]   w_pcInc;
  logic [SP_W-1:0]     r_sp;
  logic [SP_W-1:0]     w_spNext;
  logic [SP_W-1:0]     w_spInc;
  logic [SP_W-1:0]     w_spDec;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_countNext;
  logic                r_overflow;
  logic                w_overflowNext;
  logic                r_underflow;
  logic                w_underflowNext;
  logic                r_secondWord;
  logic                w_secondNext;
  logic                w_doPush;
  logic                w_x3End;
  logic                w_m1End;
  logic                w_m2End;
  logic [DATA_W-1:0]   r_opr;
  logic [DATA_W-1:0]   r_opa;
  logic [2*DATA_W-1:0] r_operand;
  logic [ADDR_W-1:0]   r_stack [STACK_DEPTH];

  assign w_x3End = (r_phase == PH_X3) && !stall;
  assign w_m1End = (r_phase == PH_M1) && !stall;
  assign w_m2End = (r_phase == PH_M2) && !stall;
  assign w_pcInc = r_pc + ADDR_W'(1);
  assign w_spInc = (r_sp == c_SP_TOP) ? '0 : r_sp + SP_W'(1);
  assign w_spDec = (r_sp == '0) ? c_SP_TOP : r_sp - SP_W'(1);

  // Phase sequencer: free-running 0..7 unless stalled
  always_comb begin
    w_phaseNext = r_phase;
    if (!stall) begin
      w_phaseNext = phase_t'(r_phase + 3'd1);
    end
  end

  // Control requests are only honoured at the X3 edge that closes an instruction
  always_comb begin
    w_secondNext    = r_secondWord;
    w_pcNext        = r_pc;
    w_spNext        = r_sp;
    w_countNext     = r_count;
    w_overflowNext  = r_overflow;
    w_underflowNext = r_underflow;
    w_doPush        = 1'b0;
    if (w_x3End) begin
      w_secondNext = longInstr & ~r_secondWord;
      if (w_secondNext) begin
        w_pcNext = w_pcInc;
      end else if (pop) begin
        w_spNext = w_spDec;
        w_pcNext = r_stack[w_spDec];
        if (r_count == '0) begin
          w_underflowNext = 1'b1;
        end else begin
          w_countNext = r_count - CNT_W'(1);
        end
      end else if (push) begin
        w_doPush = 1'b1;
        w_spNext = w_spInc;
        w_pcNext = pcNew;
        if (r_count == c_FULL) begin
          w_overflowNext = 1'b1;
        end else begin
          w_countNext = r_count + CNT_W'(1);
        end
      end else if (pcLoad) begin
        w_pcNext = pcNew;
      end else begin
        w_pcNext = w_pcInc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase      <= PH_A1;
      r_pc         <= '0;
      r_sp         <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_secondWord <= 1'b0;
      r_opr        <= '0;
      r_opa        <= '0;
      r_operand    <= '0;
    end else begin
      r_phase      <= w_phaseNext;
      r_pc         <= w_pcNext;
      r_sp         <= w_spNext;
      r_count      <= w_countNext;
      r_overflow   <= w_overflowNext;
      r_underflow  <= w_underflowNext;
      r_secondWord <= w_secondNext;
      if (w_m1End) begin
        if (r_secondWord) begin
          r_operand[2*DATA_W-1:DATA_W] <= romData;
        end else begin
          r_opr <= romData;
        end
      end
      if (w_m2End) begin
        if (r_secondWord) begin
          r_operand[DATA_W-1:0] <= romData;
        end else begin
          r_opa <= romData;
        end
      end
    end
  end

  // Return address is the PC of the following instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else if (w_doPush) begin
      r_stack[r_sp] <= w_pcInc;
    end
  end

  always_comb begin
    busNibble = '0;
    case (r_phase)
      PH_A1:   busNibble = r_pc[DATA_W-1:0];
      PH_A2:   busNibble = r_pc[2*DATA_W-1:DATA_W];
      PH_A3:   busNibble = r_pc[3*DATA_W-1:2*DATA_W];
      default: busNibble = '0;
    endcase
  end

  assign cycle      = r_phase;
  assign sync       = (r_phase == PH_A1);
  assign pcAddr     = r_pc;
  assign opr        = r_opr;
  assign opa        = r_opa;
  assign operand    = r_operand;
  assign secondWord = r_secondWord;
  assign sp         = r_sp;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  // Gated so the pulse stays single-cycle under stall and is suppressed by reset
  assign instrValid = (r_phase == PH_X1) && !stall && !rst &&
                      (r_secondWord || !longInstr);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_sequencer
// Brief   : Scoreboard bench for fetch_sequencer (PC sequence, stack, fetch).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [3:0]  romData = '0;
  logic        longInstr = 1'b0;
  logic        pcLoad = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [11:0] pcNew = '0;
  logic [2:0]  cycle;
  logic        sync;
  logic [3:0]  busNibble;
  logic [11:0] pcAddr;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic [7:0]  operand;
  logic        secondWord;
  logic        instrValid;
  logic [1:0]  sp;
  logic        overflow;
  logic        underflow;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .DATA_W(4), .ADDR_W(12), .STACK_DEPTH(3), .SP_W(2)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .romData(romData),
    .longInstr(longInstr), .pcLoad(pcLoad), .push(push), .pop(pop),
    .pcNew(pcNew), .cycle(cycle), .sync(sync), .busNibble(busNibble),
    .pcAddr(pcAddr), .opr(opr), .opa(opa), .operand(operand),
    .secondWord(secondWord), .instrValid(instrValid), .sp(sp),
    .overflow(overflow), .underflow(underflow)
  );

  int checks = 0;
  int errors = 0;

  logic [11:0] pcQ[$];
  logic [15:0] instrQ[$];

  logic [11:0] mPc;
  logic [1:0]  mSp;
  int          mCount;
  logic [11:0] mStack[3];
  logic        mOvf;
  logic        mUnf;
  logic        mSecond;
  logic [3:0]  mOpr;
  logic [3:0]  mOpa;
  logic [7:0]  mOperand;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    stall = 1'b0; romData = '0; longInstr = 1'b0;
    pcLoad = 1'b0; push = 1'b0; pop = 1'b0; pcNew = '0;
  endtask

  task automatic modelReset();
    mPc = '0; mSp = '0; mCount = 0; mOvf = 1'b0; mUnf = 1'b0; mSecond = 1'b0;
    mOpr = '0; mOpa = '0; mOperand = '0;
    for (int i = 0; i < 3; i++) mStack[i] = '0;
    pcQ.delete();
    instrQ.delete();
    pcQ.push_back(12'h000);
  endtask

  task automatic checkResetVals(input string tag);
    #1;
    checkEq({tag, "_cycle"}, cycle, 0);
    checkEq({tag, "_sync"}, sync, 1);
    checkEq({tag, "_pcAddr"}, pcAddr, 0);
    checkEq({tag, "_busNibble"}, busNibble, 0);
    checkEq({tag, "_opr"}, opr, 0);
    checkEq({tag, "_opa"}, opa, 0);
    checkEq({tag, "_operand"}, operand, 0);
    checkEq({tag, "_secondWord"}, secondWord, 0);
    checkEq({tag, "_instrValid"}, instrValid, 0);
    checkEq({tag, "_sp"}, sp, 0);
    checkEq({tag, "_overflow"}, overflow, 0);
    checkEq({tag, "_underflow"}, underflow, 0);
  endtask

  // Ends at the negedge where rst has just been released (DUT in phase 0)
  task automatic applyReset(input string tag);
    idleInputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkResetVals(tag);
  endtask

  // One full 8-phase instruction cycle starting at a phase-0 negedge
  task automatic doCycle(input logic [3:0] r1, input logic [3:0] r2, input logic li,
                         input logic ps, input logic pp, input logic ld,
                         input logic [11:0] tgt);
    logic [11:0] expPc;
    logic [15:0] expI;
    logic        expValid;
    logic        nextSecond;
    expPc = (pcQ.size() != 0) ? pcQ.pop_front() : mPc;
    expValid = mSecond | ~li;
    for (int ph = 0; ph < 8; ph++) begin
      romData   = (ph == 3) ? r1 : ((ph == 4) ? r2 : 4'h0);
      longInstr = (ph >= 5) ? li : 1'b0;
      push      = (ph >= 5) ? ps : 1'b0;
      pop       = (ph >= 5) ? pp : 1'b0;
      pcLoad    = (ph >= 5) ? ld : 1'b0;
      pcNew     = tgt;
      #1;
      checkEq("cycle", cycle, ph);
      checkEq("sync", sync, ph == 0);
      checkEq("pcAddr", pcAddr, expPc);
      case (ph)
        0:       checkEq("busNibble", busNibble, expPc[3:0]);
        1:       checkEq("busNibble", busNibble, expPc[7:4]);
        2:       checkEq("busNibble", busNibble, expPc[11:8]);
        default: checkEq("busNibble", busNibble, 0);
      endcase
      checkEq("secondWord", secondWord, mSecond);
      checkEq("instrValid", instrValid, (ph == 5) && expValid);
      if (ph == 0) begin
        checkEq("sp", sp, mSp);
        checkEq("overflow", overflow, mOvf);
        checkEq("underflow", underflow, mUnf);
        checkEq("regs", {opr, opa, operand}, {mOpr, mOpa, mOperand});
      end
      if (ph == 4) begin
        if (mSecond) mOperand = {r1, r2};
        else begin mOpr = r1; mOpa = r2; end
        if (expValid) instrQ.push_back({mOpr, mOpa, mOperand});
      end
      if (ph == 5 && instrValid && instrQ.size() != 0) begin
        expI = instrQ.pop_front();
        checkEq("instr", {opr, opa, operand}, expI);
      end
      @(negedge clk);
    end
    nextSecond = li & ~mSecond;
    if (nextSecond) mPc = mPc + 12'h1;
    else if (pp) begin
      mSp = (mSp == 2'd0) ? 2'd2 : mSp - 2'd1;
      mPc = mStack[mSp];
      if (mCount == 0) mUnf = 1'b1; else mCount--;
    end else if (ps) begin
      mStack[mSp] = mPc + 12'h1;
      mSp = (mSp == 2'd2) ? 2'd0 : mSp + 2'd1;
      if (mCount == 3) mOvf = 1'b1; else mCount++;
      mPc = tgt;
    end else if (ld) mPc = tgt;
    else mPc = mPc + 12'h1;
    mSecond = nextSecond;
    pcQ.push_back(mPc);
    idleInputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Plain sequencing with ROM zeros
    applyReset("rst0");
    repeat (3) doCycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

    // Two-word instruction
    applyReset("rst1");
    doCycle(4'h4, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    doCycle(4'h3, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    #1;
    checkEq("long_opr", opr, 4'h4);
    checkEq("long_opa", opa, 4'h2);
    checkEq("long_operand", operand, 8'h35);
    checkEq("long_pc", pcAddr, 12'h002);

    // Call / return
    doCycle(4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123);
    doCycle(4'h5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h400);
    #1;
    checkEq("call_pc", pcAddr, 12'h400);
    checkEq("call_sp", sp, 2'd1);
    doCycle(4'hC, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    doCycle(4'hC, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    #1;
    checkEq("ret_pc", pcAddr, 12'h124);
    checkEq("ret_sp", sp, 2'd0);

    // Controls ignored mid two-word fetch, honoured on the second word
    doCycle(4'h4, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h300);
    doCycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h300);
    #1;
    checkEq("jun_pc", pcAddr, 12'h300);

    // Overflow after four pushes
    applyReset("rst2");
    for (int i = 0; i < 4; i++)
      doCycle(4'h5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010 * (i + 1));
    #1;
    checkEq("ovf_flag", overflow, 1'b1);
    for (int i = 0; i < 3; i++)
      doCycle(4'hC, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);

    // Underflow from an empty stack, flags sticky until reset
    applyReset("rst3");
    doCycle(4'hC, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    doCycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    doCycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    #1;
    checkEq("unf_sticky", underflow, 1'b1);
    applyReset("rst4");

    // PC wrap and pop priority over pcLoad
    doCycle(4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 12'hFFF);
    doCycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    #1;
    checkEq("wrap_pc", pcAddr, 12'h000);
    doCycle(4'h5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h050);
    doCycle(4'hC, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h777);
    #1;
    checkEq("prio_pc", pcAddr, 12'h001);
    doCycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

    // Stall in A3, then reset in X2 aborting a fetch
    applyReset("rst5");
    @(negedge clk);
    @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checkEq("stall_cycle", cycle, 3'd2);
      checkEq("stall_pc", pcAddr, 12'h000);
    end
    stall = 1'b0;
    @(negedge clk);
    #1;
    checkEq("unstall_cycle", cycle, 3'd3);
    romData = 4'hA;
    @(negedge clk);
    @(negedge clk);
    romData = 4'h0;
    @(negedge clk);
    #1;
    checkEq("pre_rst_cycle", cycle, 3'd6);
    checkEq("pre_rst_opr", opr, 4'hA);
    rst = 1'b1;
    #1;
    checkEq("rst_instrValid", instrValid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkResetVals("abort");
    doCycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    #1;
    checkEq("final_pc", pcAddr, (pcQ.size() != 0) ? pcQ.pop_front() : 12'hFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
